hack_cpu_ctrl: RTL and testbench

Multi-cycle Hack control/datapath core that sits in front of the existing Hack ALU and drives it. It fetches instructions from ROM and decodes A- and C-instructions. It drives the six ALU control bits and the x/y operands, then captures the ALU result and flags. It owns the A, D and PC registers and performs data-memory reads and writes over req/ack handshakes.

---
 rtl/hack_pkg.sv | 44 ++++
 rtl/hack_jump_eval.sv | 16 +
 rtl/hack_cpu_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared state enum and instruction field constants for the Hack control core
package hack_pkg;

  // HALT only exists when HACK_HALT_DETECT_EN is defined
`ifdef HACK_HALT_DETECT_EN
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MREAD  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MWRITE = 3'd4,
    ST_HALT   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MREAD  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MWRITE = 3'd4
  } state_t;
`endif

  // instruction word field positions
  localparam int IS_C    = 15;
  localparam int A_BIT   = 12;
  localparam int CTRL_HI = 11;
  localparam int CTRL_LO = 6;
  localparam int DEST_HI = 5;
  localparam int DEST_LO = 3;
  localparam int JMP_HI  = 2;
  localparam int JMP_LO  = 0;

  // bit positions inside the 3-bit dest field
  localparam int D_A = 2;
  localparam int D_D = 1;
  localparam int D_M = 0;

  // bit positions inside the 3-bit jump field
  localparam int J_LT = 2;
  localparam int J_EQ = 1;
  localparam int J_GT = 0;

endpackage

// File: rtl/hack_jump_eval.sv
// rtl/hack_jump_eval.sv - combinational jump condition from the jump field and ALU flags
module hack_jump_eval
  import hack_pkg::*;
(
  input  logic [2:0] jmp,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  // positive means neither negative nor zero
  always_comb begin
    take = (jmp[J_LT] & ng) | (jmp[J_EQ] & zr) | (jmp[J_GT] & ~ng & ~zr);
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// rtl/hack_cpu_ctrl.sv - multi-cycle Hack control/datapath core (optional HACK_HALT_DETECT_EN)
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'd0,
  parameter int          ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [15:0]       rom_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic [5:0]        alu_ctrl,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [15:0]       pc_out,
  output logic              halted
);

  state_t      state;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [15:0] m_reg;
  logic [15:0] instr;
  logic [15:0] pc;
  logic [15:0] old_a;
  logic        take;
  logic        take_r;
  logic [2:0]  dest;
  logic [2:0]  jmp;

  assign dest     = instr[DEST_HI:DEST_LO];
  assign jmp      = instr[JMP_HI:JMP_LO];
  assign rom_addr = pc[ADDR_W-1:0];
  assign pc_out   = pc;
  assign alu_x    = d_reg;
  assign alu_y    = instr[A_BIT] ? m_reg : a_reg;
  assign alu_ctrl = instr[CTRL_HI:CTRL_LO];

`ifdef HACK_HALT_DETECT_EN
  logic halted_r;
  logic halt_hit;
  // an unconditional jump onto itself can never make progress
  assign halt_hit = (jmp == 3'b111) && (a_reg == pc);
  assign halted   = halted_r;
`else
  assign halted = 1'b0;
`endif

  hack_jump_eval u_jump_eval (
    .jmp  (jmp),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (take)
  );

  // sequencer: fetch, decode, optional M read, execute, optional M write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      rom_req   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 16'd0;
      a_reg     <= 16'd0;
      d_reg     <= 16'd0;
      m_reg     <= 16'd0;
      instr     <= 16'd0;
      pc        <= PC_RESET;
      old_a     <= 16'd0;
      take_r    <= 1'b0;
`ifdef HACK_HALT_DETECT_EN
      halted_r  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
          // request goes up one cycle after entry so a stale ack cannot be taken
          if (!rom_req) begin
            rom_req <= 1'b1;
          end else if (rom_ack) begin
            instr   <= rom_data;
            rom_req <= 1'b0;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!instr[IS_C]) begin
            a_reg <= instr;
            pc    <= pc + 16'd1;
            state <= ST_FETCH;
          end else if (instr[A_BIT]) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= a_reg[ADDR_W-1:0];
            state    <= ST_MREAD;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_MREAD: begin
          if (mem_ack) begin
            m_reg   <= mem_rdata;
            mem_req <= 1'b0;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (dest[D_A]) a_reg <= alu_out;
          if (dest[D_D]) d_reg <= alu_out;
          // keep pre-write A and the flags for a jump resolved after MWRITE
          old_a  <= a_reg;
          take_r <= take;
`ifdef HACK_HALT_DETECT_EN
          if (halt_hit) halted_r <= 1'b1;
`endif
          if (dest[D_M]) begin
            mem_wdata <= alu_out;
            mem_addr  <= a_reg[ADDR_W-1:0];
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            state     <= ST_MWRITE;
          end else begin
            pc <= take ? a_reg : pc + 16'd1;
`ifdef HACK_HALT_DETECT_EN
            state <= halt_hit ? ST_HALT : ST_FETCH;
`else
            state <= ST_FETCH;
`endif
          end
        end
        ST_MWRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            pc      <= take_r ? old_a : pc + 16'd1;
`ifdef HACK_HALT_DETECT_EN
            state   <= halted_r ? ST_HALT : ST_FETCH;
`else
            state   <= ST_FETCH;
`endif
          end
        end
`ifdef HACK_HALT_DETECT_EN
        ST_HALT: begin
          state <= ST_HALT;
        end
`endif
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb/tb_hack_cpu_ctrl.sv - instruction-level model bench for hack_cpu_ctrl (HACK_HALT_DETECT_EN aware)
module tb_hack_cpu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctrl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [15:0] pc_out;
  logic        halted;

  hack_cpu_ctrl #(.PC_RESET(16'd0), .ADDR_W(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc_out(pc_out), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hack ALU: returns {zr, ng, out}
  function automatic logic [17:0] alu_f(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'd0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'd0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? xx + yy : xx & yy;
    o  = c[0] ? ~o : o;
    return {(o == 16'd0), o[15], o};
  endfunction

  assign {alu_zr, alu_ng, alu_out} = alu_f(alu_x, alu_y, alu_ctrl);

  logic [15:0] rom  [0:32767];
  logic [15:0] eram [0:32767];
  logic [15:0] mram [0:32767];
  logic [31:0] mem_log[$];
  logic [31:0] exp_q[$];
  logic [15:0] mpc, ma, md;
  int rom_wait, rom_cur_wait, rom_cnt, mem_wait, mem_cnt;
  logic in_fetch;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // one clock, then play ROM and RAM responders with configurable wait states
  task automatic tick();
    @(posedge clk);
    #1;
    rom_ack = 1'b0;
    mem_ack = 1'b0;
    if (rst_n && rom_req) begin
      if (!in_fetch) begin
        in_fetch = 1'b1;
        rom_cur_wait = rom_wait;
        rom_cnt = 0;
      end
      if (rom_cnt >= rom_cur_wait) begin
        rom_ack = 1'b1;
        rom_data = rom[rom_addr];
        in_fetch = 1'b0;
      end else rom_cnt++;
    end
    if (rst_n && mem_req) begin
      if (mem_cnt >= mem_wait) begin
        mem_ack = 1'b1;
        mem_cnt = 0;
        if (mem_we) begin
          eram[mem_addr] = mem_wdata;
          mem_log.push_back({1'b1, mem_addr, mem_wdata});
        end else begin
          mem_rdata = eram[mem_addr];
          mem_log.push_back({1'b0, mem_addr, mem_rdata});
        end
      end else mem_cnt++;
    end
  endtask

  // architectural effect of the instruction at mpc, plus its expected cycle count
  task automatic model_step(input int rw, input int mw, output int exp_cyc);
    logic [15:0] ins, olda, y, o;
    logic [17:0] r;
    logic take;
    ins = rom[mpc[14:0]];
    exp_q.delete();
    if (!ins[15]) begin
      ma = ins;
      mpc = mpc + 16'd1;
      exp_cyc = 3 + rw;
    end else begin
      olda = ma;
      exp_cyc = 4 + rw;
      if (ins[12]) begin
        y = mram[olda[14:0]];
        exp_q.push_back({1'b0, olda[14:0], y});
        exp_cyc += 1 + mw;
      end else y = ma;
      r = alu_f(md, y, ins[11:6]);
      o = r[15:0];
      if (ins[5]) ma = o;
      if (ins[4]) md = o;
      if (ins[3]) begin
        mram[olda[14:0]] = o;
        exp_q.push_back({1'b1, olda[14:0], o});
        exp_cyc += 1 + mw;
      end
      take = ($signed(o) < 0 && ins[2]) || (o == 16'd0 && ins[1]) || ($signed(o) > 0 && ins[0]);
      mpc = take ? olda : mpc + 16'd1;
    end
  endtask

  // called right after rom_req rises for an instruction; runs until the next rise
  task automatic run_instr(input string tag, input int mw, input int next_rw);
    int my_rw, exp_cyc, n, hi;
    logic prev, done;
    my_rw = rom_cur_wait;
    mem_wait = mw;
    rom_wait = next_rw;
    mem_log.delete();
    model_step(my_rw, mw, exp_cyc);
    prev = 1'b1; n = 0; hi = 1; done = 1'b0;
    while (!done && n < 400) begin
      tick();
      n++;
      if (rom_req && !prev) done = 1'b1;
      else begin
        if (rom_req) hi++;
        prev = rom_req;
      end
    end
    chk({tag, "/done"}, 32'(done), 32'd1);
    chk({tag, "/cycles"}, n, exp_cyc);
    chk({tag, "/req_hi"}, hi, 1 + my_rw);
    chk({tag, "/rom_addr"}, rom_addr, mpc[14:0]);
    chk({tag, "/pc"}, pc_out, mpc);
    chk({tag, "/D"}, alu_x, md);
    chk({tag, "/A"}, dut.a_reg, ma);
    chk({tag, "/nmem"}, mem_log.size(), exp_q.size());
    for (int i = 0; i < mem_log.size() && i < exp_q.size(); i++)
      chk({tag, "/mem"}, mem_log[i], exp_q[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rom_ack = 1'b0; mem_ack = 1'b0;
    in_fetch = 1'b0; rom_cnt = 0; mem_cnt = 0;
    mem_log.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst/rom_req", rom_req, 0);
    chk("rst/mem_req", mem_req, 0);
    chk("rst/mem_we", mem_we, 0);
    chk("rst/pc", pc_out, 16'd0);
    chk("rst/alu_x", alu_x, 0);
    chk("rst/alu_y", alu_y, 0);
    chk("rst/alu_ctrl", alu_ctrl, 0);
    chk("rst/mem_addr", mem_addr, 0);
    chk("rst/mem_wdata", mem_wdata, 0);
    chk("rst/halted", halted, 0);
    rst_n = 1'b1;
    mpc = 16'd0; ma = 16'd0; md = 16'd0;
    // stray ack before the request is up must be ignored
    rom_ack = 1'b1;
    rom_data = 16'hEC10;
    tick();
    chk("rst/req_rise", rom_req, 1);
    chk("rst/fetch0", rom_addr, 15'd0);
  endtask

  initial begin
    int found;
    logic [15:0] w;
    rst_n = 1'b0; rom_ack = 1'b0; mem_ack = 1'b0;
    rom_data = 16'd0; mem_rdata = 16'd0;
    rom_wait = 0; rom_cur_wait = 0; mem_wait = 0; in_fetch = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'd0; eram[i] = 16'd0; mram[i] = 16'd0;
    end

    // directed program: A-load, D=A, AM=M+1, jumps
    rom[0] = 16'h0015; rom[1] = 16'h0005; rom[2] = 16'hEC10; rom[3] = 16'h0064;
    rom[4] = 16'hFDE8; rom[5] = 16'h0000; rom[6] = 16'hEC10; rom[7] = 16'h0028;
    rom[8] = 16'hE302;
    rom[40] = 16'h7FFF; rom[41] = 16'hEC10; rom[42] = 16'hE7D0; rom[43] = 16'h0028;
    rom[44] = 16'hE301; rom[45] = 16'hE304;
    eram[100] = 16'd7; mram[100] = 16'd7;
    do_reset();
    run_instr("a21", 0, 0);
    chk("a21/A", dut.a_reg, 16'd21);
    chk("a21/pc", pc_out, 16'd1);
    run_instr("a5", 0, 0);
    run_instr("d_eq_a", 0, 0);
    chk("d_eq_a/ctrl", alu_ctrl, 6'b110000);
    chk("d_eq_a/y", alu_y, 16'd5);
    chk("d_eq_a/D", alu_x, 16'd5);
    run_instr("a100", 0, 0);
    run_instr("am_inc", 2, 0);
    chk("am_inc/A", dut.a_reg, 16'd8);
    chk("am_inc/ram", eram[100], 16'd8);
    run_instr("a0", 0, 0);
    run_instr("d0", 0, 0);
    run_instr("a40", 0, 0);
    run_instr("jeq", 0, 1);
    chk("jeq/pc", pc_out, 16'd40);
    run_instr("a7fff", 0, 0);
    run_instr("d_a", 0, 0);
    run_instr("d_inc", 0, 0);
    run_instr("a40b", 0, 0);
    run_instr("jgt", 0, 0);
    chk("jgt/pc", pc_out, 16'd45);
    run_instr("jlt", 0, 0);
    chk("jlt/pc", pc_out, 16'd40);

    // reset in the middle of a stalled M write
    rom[0] = 16'h00C8; rom[1] = 16'hE308;
    eram[200] = 16'h1234; mram[200] = 16'h1234;
    rom_wait = 0;
    do_reset();
    run_instr("a200", 0, 0);
    mem_wait = 50;
    mem_log.delete();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (mem_req && mem_we) found = 1;
    end
    chk("mrst/in_write", found, 1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst/mem_req", mem_req, 0);
    chk("mrst/mem_we", mem_we, 0);
    chk("mrst/rom_req", rom_req, 0);
    chk("mrst/nwrite", mem_log.size(), 0);
    chk("mrst/ram", eram[200], 16'h1234);
    mem_wait = 0;
    rom_wait = 0;
    do_reset();
    run_instr("mrst/a200", 0, 0);

    // random programs with random wait states
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if (w[15]) begin
        w[14:13] = 2'b11;
        if (w[2:0] == 3'b111) w[2:0] = 3'b000;
      end
      rom[i] = w;
      w = 16'($urandom);
      eram[i] = w; mram[i] = w;
    end
    rom_wait = int'($urandom_range(0, 2));
    do_reset();
    for (int k = 0; k < 150; k++)
      run_instr("rnd", int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

    // self-jump: @6; 0;JMP at 1, then @7; 0;JMP at 7
    rom[0] = 16'h0006; rom[1] = 16'hEA87; rom[6] = 16'h0007; rom[7] = 16'hEA87;
    rom_wait = 0;
    do_reset();
    run_instr("h0", 0, 0);
    run_instr("h1", 0, 0);
    run_instr("h6", 0, 0);
`ifdef HACK_HALT_DETECT_EN
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      tick();
      if (halted) found = 1;
    end
    chk("halt/set", found, 1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rom_req || mem_req) found++;
    end
    chk("halt/no_req", found, 0);
    chk("halt/still", halted, 1);
`else
    run_instr("h7a", 0, 0);
    chk("loop/addr_a", rom_addr, 15'd7);
    run_instr("h7b", 0, 0);
    chk("loop/addr_b", rom_addr, 15'd7);
    chk("loop/halted", halted, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
